// File: rtl/idct_2d_if.sv
// rtl/idct_2d_if.sv - coefficient load, start and result write bus of idct_2d
interface idct_2d_if;
  logic        rdy;
  logic        en;
  logic [5:0]  iaddr;
  logic [7:0]  idata;
  logic        iwren;
  logic [15:0] mq;
  logic [5:0]  waddr;
  logic [15:0] wdata;
  logic        wwren;

  modport master (input rdy, waddr, wdata, wwren, output en, iaddr, idata, iwren, mq);
  modport slave  (output rdy, waddr, wdata, wwren, input en, iaddr, idata, iwren, mq);
endinterface

// File: rtl/idct_2d.sv
// rtl/idct_2d.sv - MPEG-2 intra inverse quantiser and 8x8 2-D IDCT on one MAC
module idct_2d #(
  parameter int CW = 12,
  parameter int KW = 13
) (
  input  logic     clk,
  input  logic     reset_n,
  idct_2d_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_CLR} state_t;

  state_t r_state, w_next;

  logic signed [CW-1:0] r_coef [64];
  logic signed [15:0]   r_tmp  [64];
  logic [8:0]           r_cnt;    // {outer index, output index, MAC tap}
  logic signed [31:0]   r_acc;
  logic [5:0]           r_waddr;
  logic [15:0]          r_wdata;
  logic                 r_wwren;

  logic [2:0]           w_oi, w_in, w_k;
  logic                 w_last_mac;
  logic signed [25:0]   w_dq_prod, w_dq_adj, w_dq_div;
  logic signed [CW-1:0] w_dq_sat;
  logic signed [KW-1:0] w_c;
  logic signed [15:0]   w_d;
  logic signed [31:0]   w_prod, w_sum, w_col;
  logic [15:0]          w_row;
  logic signed [8:0]    w_pix;

  // Q12 cosine C[k][n]; the angle (2n+1)k mod 32 is folded onto the first quadrant
  function automatic logic signed [KW-1:0] cos_q12(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]           a;
    logic [4:0]           m;
    logic                 neg;
    logic signed [KW-1:0] mag;
    a = 5'({n, 1'b1} * {2'b00, k});
    if (a <= 5'd8) begin
      m = a;          neg = 1'b0;
    end else if (a <= 5'd16) begin
      m = 5'd16 - a;  neg = 1'b1;
    end else if (a <= 5'd24) begin
      m = a - 5'd16;  neg = 1'b1;
    end else begin
      m = 5'd0 - a;   neg = 1'b0;
    end
    case (m)
      5'd0:    mag = 13'sd2048;
      5'd1:    mag = 13'sd2009;
      5'd2:    mag = 13'sd1892;
      5'd3:    mag = 13'sd1703;
      5'd4:    mag = 13'sd1448;
      5'd5:    mag = 13'sd1138;
      5'd6:    mag = 13'sd784;
      5'd7:    mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    if (k == 3'd0) begin
      mag = 13'sd1448;
      neg = 1'b0;
    end
    return neg ? -mag : mag;
  endfunction

  assign w_oi       = r_cnt[8:6];
  assign w_in       = r_cnt[5:3];
  assign w_k        = r_cnt[2:0];
  assign w_last_mac = (w_k == 3'd7);

  // dequantise: QF*2*mq/32 truncated toward zero, then clamped to the coefficient range
  assign w_dq_prod = $signed(26'($signed(bus.idata))) * $signed({9'd0, bus.mq, 1'b0});
  assign w_dq_adj  = w_dq_prod + (w_dq_prod[25] ? 26'sd31 : 26'sd0);
  assign w_dq_div  = w_dq_adj >>> 5;
  assign w_dq_sat  = (w_dq_div > 26'sd2047)  ? 12'sd2047 :
                     (w_dq_div < -26'sd2048) ? -12'sd2048 : w_dq_div[CW-1:0];

  // ROW walks coef[8v+u] along a row; COL walks tmp[8v+x] down a column
  assign w_c    = cos_q12(w_k, w_in);
  assign w_d    = (r_state == S_COL) ? r_tmp[{w_k, w_oi}] : 16'(r_coef[{w_oi, w_k}]);
  assign w_prod = $signed(32'(w_c)) * $signed(32'(w_d));
  assign w_sum  = r_acc + w_prod;
  assign w_row  = 16'((w_sum + 32'sd256) >>> 9);
  assign w_col  = (w_sum + 32'sd16384) >>> 15;
  assign w_pix  = (w_col > 32'sd255)  ? 9'sd255 :
                  (w_col < -32'sd256) ? -9'sd256 : w_col[8:0];

  assign bus.rdy   = (r_state == S_IDLE);
  assign bus.waddr = r_waddr;
  assign bus.wdata = r_wdata;
  assign bus.wwren = r_wwren;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next state: both passes are 512 MAC cycles, then one clear cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.en) w_next = S_ROW;
      S_ROW:   if (r_cnt == 9'd511) w_next = S_COL;
      S_COL:   if (r_cnt == 9'd511) w_next = S_CLR;
      S_CLR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // coefficient load, MAC sequencing, intermediate store and result emission
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        r_coef[i] <= '0;
        r_tmp[i]  <= '0;
      end
      r_cnt   <= '0;
      r_acc   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wwren <= 1'b0;
    end else begin
      r_wwren <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        r_acc <= '0;
        if (bus.iwren) r_coef[bus.iaddr] <= w_dq_sat;
      end else if (r_state == S_CLR) begin
        for (int i = 0; i < 64; i++) r_coef[i] <= '0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 9'd1;
        r_acc <= w_last_mac ? 32'sd0 : w_sum;
        if (w_last_mac) begin
          if (r_state == S_ROW) begin
            r_tmp[{w_oi, w_in}] <= w_row;
          end else begin
            r_wwren <= 1'b1;
            r_waddr <= {w_in, w_oi};
            r_wdata <= 16'(w_pix);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_2d.sv
// tb/tb_idct_2d.sv - randomized and directed self-checking bench for idct_2d
module tb_idct_2d;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  idct_2d_if bus();

  idct_2d dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_coef  [64];
  int exp_pix [64];
  int got     [64];
  int ctab    [8][8];

  task automatic check_eq(input string tag, input int got_v, input int exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
  endtask

  function automatic int cos_ref(input int k, input int n);
    real ck, v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 4096.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    return (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic int dequant(input int d, input int m);
    byte sd;
    int  q;
    sd = byte'(d);
    q  = (int'(sd) * 2 * m) / 32;
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  function automatic void model_block();
    int tmp [64];
    int s;
    for (int v = 0; v < 8; v++)
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int u = 0; u < 8; u++) s += ctab[u][n] * m_coef[8 * v + u];
        tmp[8 * v + n] = int'(shortint'((s + 256) >>> 9));
      end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        s = 0;
        for (int v = 0; v < 8; v++) s += ctab[v][y] * tmp[8 * v + x];
        s = (s + 16384) >>> 15;
        if (s > 255)  s = 255;
        if (s < -256) s = -256;
        exp_pix[8 * y + x] = s;
      end
  endfunction

  task automatic load(input int a, input int d, input int m);
    bus.iaddr = 6'(a);
    bus.idata = 8'(d);
    bus.mq    = 16'(m);
    bus.iwren = 1'b1;
    @(negedge clk);
    bus.iwren = 1'b0;
    m_coef[a] = dequant(d, m);
  endtask

  task automatic run_block(input string name, input bit busy_wr);
    int  n_wr, cyc, last, a;
    bit  done;
    n_wr = 0; cyc = 0; last = 0; done = 1'b0;
    for (int i = 0; i < 64; i++) got[i] = 32'h7fff_ffff;
    model_block();
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    check_eq({name, "_busy"}, int'(bus.rdy), 0);
    cyc = 1;
    while (!done && cyc < 1500) begin
      if (busy_wr && cyc == 5) begin
        bus.iaddr = 6'd0; bus.idata = 8'h7F; bus.mq = 16'hFFFF; bus.iwren = 1'b1;
      end else begin
        bus.iwren = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (bus.wwren) begin
        a = int'(bus.waddr);
        check_eq({name, "_order"}, a, 8 * (n_wr % 8) + n_wr / 8);
        got[a] = int'($signed(bus.wdata));
        n_wr++;
        last = cyc;
      end
      if (bus.rdy) done = 1'b1;
    end
    bus.iwren = 1'b0;
    check_eq({name, "_done"}, int'(done), 1);
    check_eq({name, "_nwr"}, n_wr, 64);
    check_eq({name, "_lat"}, int'(last <= 1200), 1);
    for (int i = 0; i < 64; i++) check_eq($sformatf("%s_s%0d", name, i), got[i], exp_pix[i]);
    for (int i = 0; i < 64; i++) m_coef[i] = 0;
  endtask

  initial begin
    int k, seen, wr_after;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) ctab[a][b] = cos_ref(a, b);
    for (int i = 0; i < 64; i++) m_coef[i] = 0;
    bus.en = 1'b0; bus.iwren = 1'b0; bus.iaddr = '0; bus.idata = '0; bus.mq = '0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy",   int'(bus.rdy),   1);
    check_eq("rst_wwren", int'(bus.wwren), 0);
    check_eq("rst_waddr", int'(bus.waddr), 0);
    check_eq("rst_wdata", int'(bus.wdata), 0);

    run_block("empty", 1'b0);

    load(0, 8'h08, 16);
    run_block("dc", 1'b0);
    check_eq("dc_first", got[0], 1);
    check_eq("dc_last",  got[63], 1);

    run_block("b2b", 1'b1);
    check_eq("b2b_zero", got[27], 0);

    load(0, 8'hF0, 16);
    run_block("negdc", 1'b0);
    check_eq("negdc_val", got[9], -2);

    load(0, 8'h7F, 16'hFFFF);
    run_block("sat", 1'b0);
    check_eq("sat_val", got[45], 255);

    load(1, 8'h10, 16);
    run_block("sparse", 1'b0);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 4; x++) check_eq("antisym", got[8 * y + x], -got[8 * y + 7 - x]);
    for (int y = 1; y < 8; y++)
      for (int x = 0; x < 8; x++) check_eq("xonly", got[8 * y + x], got[x]);

    for (int b = 0; b < 4; b++) begin
      k = $urandom_range(1, 12);
      for (int j = 0; j < k; j++)
        load($urandom_range(0, 63), $urandom_range(0, 255), $urandom_range(0, 400));
      if (b == 3) load($urandom_range(0, 63), 8'h81, 16'hFFFF);
      run_block($sformatf("rnd%0d", b), 1'b0);
    end

    load(0, 8'h08, 16);
    load(10, 8'h40, 100);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    seen = 0;
    for (int c = 0; c < 1500 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.wwren) seen = 1;
    end
    check_eq("mid_reach", seen, 1);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_wwren", int'(bus.wwren), 0);
    check_eq("mid_rdy",   int'(bus.rdy),   1);
    check_eq("mid_waddr", int'(bus.waddr), 0);
    check_eq("mid_wdata", int'(bus.wdata), 0);
    for (int i = 0; i < 64; i++) m_coef[i] = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr_after = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.wwren) wr_after++;
    end
    check_eq("mid_nowr", wr_after, 0);
    run_block("postrst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
